// File: rtl/aes_diffusion_engine.sv
// aes_diffusion_engine: AES ShiftRows+MixColumns round stage; inverse path enabled by AES_DIFFUSION_INV_EN
module aes_diffusion_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    state_t state, state_n;
    logic [1:0] cnt, cnt_n, col;
    logic [127:0] work, work_n, work_mix;
    logic accept, inv_a, mix_end;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fmc(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = a;
        return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
                xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
    endfunction

    // inv=0: out[r][c] = s[r][c+r]; inv=1: out[r][c] = s[r][c-r]
    function automatic logic [127:0] sr(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int j;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                j = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*j+r) -: 8];
            end
        return o;
    endfunction

`ifdef AES_DIFFUSION_INV_EN
    logic inv_q;
    assign inv_a = in_inv;

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[0]}} & x) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = a;
        return {gm(b0, 4'he) ^ gm(b1, 4'hb) ^ gm(b2, 4'hd) ^ gm(b3, 4'h9),
                gm(b0, 4'h9) ^ gm(b1, 4'he) ^ gm(b2, 4'hb) ^ gm(b3, 4'hd),
                gm(b0, 4'hd) ^ gm(b1, 4'h9) ^ gm(b2, 4'he) ^ gm(b3, 4'hb),
                gm(b0, 4'hb) ^ gm(b1, 4'hd) ^ gm(b2, 4'h9) ^ gm(b3, 4'he)};
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst)
            inv_q <= 1'b0;
        else if (accept)
            inv_q <= in_inv;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign inv_a = 1'b0;
`endif

    always_comb begin
        work_mix = work;
        col = cnt;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col = cnt + 2'(k);
`ifdef AES_DIFFUSION_INV_EN
            work_mix[127-32*int'(col) -: 32] = inv_q ? imc(work[127-32*int'(col) -: 32])
                                                     : fmc(work[127-32*int'(col) -: 32]);
`else
            work_mix[127-32*int'(col) -: 32] = fmc(work[127-32*int'(col) -: 32]);
`endif
        end
    end

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign mix_end   = ({1'b0, cnt} + STEP) == 3'd4;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
`ifdef AES_DIFFUSION_INV_EN
    assign out_state = out_valid ? (inv_q ? sr(work, 1'b1) : work) : '0;
`else
    assign out_state = out_valid ? work : '0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        work_n  = work;
        if (state == MIX) begin
            work_n  = work_mix;
            cnt_n   = cnt + STEP[1:0];
            state_n = mix_end ? DONE : MIX;
        end else if (accept) begin
            work_n  = inv_a ? in_state : sr(in_state, 1'b0);
            cnt_n   = 2'd0;
            state_n = in_last ? DONE : MIX;
        end else if (state == DONE && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            work  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            work  <= work_n;
        end
endmodule

// File: tb/tb_aes_diffusion_engine.sv
// tb_aes_diffusion_engine: directed checks of all three column widths against a byte-matrix AES model
module tb_aes_diffusion_engine;
`ifdef AES_DIFFUSION_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif
    localparam logic [127:0] FIPS_IN = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_MC = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] DIAG_EX = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
    localparam logic [127:0] DIAG_CL = 128'hdb135345f20a225c010101012d26314c;

    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] iv = '0, ordy = '1, irdy, ov, bsy;
    logic [127:0] din = '0;
    logic dlast = 1'b0, dinv = 1'b0;
    logic [2:0][127:0] os;
    int sel = 0, nchk = 0, nerr = 0;
    logic [127:0] expq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_diffusion_engine #(.COLS_PER_CYCLE(1 << g)) u (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(irdy[g]),
            .in_state(din), .in_last(dlast), .in_inv(dinv),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_state(os[g]), .busy(bsy[g]));
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv, input logic last);
        logic [7:0] m [4][4];
        logic [7:0] t [4][4];
        logic [7:0] base [4];
        logic [127:0] o;
        bit iv2;
        iv2 = inv && INV_EN;
        if (iv2) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][c] = iv2 ? m[r][c] : m[r][(c+r)%4];
        if (!last)
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    m[r][c] = 8'h00;
                    for (int k = 0; k < 4; k++) m[r][c] = m[r][c] ^ gmul(base[(k-r+4)%4], t[k][c]);
                end
        else
            m = t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][c] = iv2 ? m[r][(c-r+4)%4] : m[r][c];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = t[r][c];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (dut %0d): got %h expected %h", name, sel, act, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && ov[sel]) begin
            if (expq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL spurious_out (dut %0d): got %h expected no output", sel, os[sel]);
            end else begin
                check("scoreboard", os[sel], expq[0]);
                if (ordy[sel]) void'(expq.pop_front());
            end
        end

    task automatic send(input logic [127:0] d, input logic inv, input logic last);
        int t = 0;
        logic acc = 1'b0;
        din = d; dinv = inv; dlast = last; iv[sel] = 1'b1;
        while (!acc && t < 50) begin
            acc = irdy[sel];
            if (acc) expq.push_back(model(d, inv, last));
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout (dut %0d): got no accept expected accept", sel);
        end
        iv[sel] = 1'b0; dinv = ~inv; dlast = ~last; din = ~d;
    endtask

    task automatic wait_out(input int lat, input string name);
        int t = 0;
        while (!ov[sel] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_latency"}, 128'(t), 128'(lat));
    endtask

    task automatic do_reset();
        rst = 1'b1; iv = '0; ordy = '1;
        @(posedge clk); #1;
        check("rst_out_valid", 128'(ov[sel]), 128'(0));
        check("rst_out_state", os[sel], 128'(0));
        check("rst_busy", 128'(bsy[sel]), 128'(0));
        expq.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 128'(irdy[sel]), 128'(1));
    endtask

    task automatic backpressure(input int n);
        logic [127:0] a, b;
        a = 128'h00112233445566778899aabbccddeeff;
        b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        @(posedge clk); #1;
        ordy[sel] = 1'b0; #1;
        send(a, 1'b0, 1'b0);
        wait_out(n, "bp");
        din = b; dinv = 1'b0; dlast = 1'b0; iv[sel] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold", os[sel], model(a, 1'b0, 1'b0));
            check("bp_in_ready", 128'(irdy[sel]), 128'(0));
            check("bp_out_valid", 128'(ov[sel]), 128'(1));
        end
        ordy[sel] = 1'b1; #1;
        check("b2b_in_ready", 128'(irdy[sel]), 128'(1));
        expq.push_back(model(b, 1'b0, 1'b0));
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        check("b2b_busy", 128'(bsy[sel]), 128'(1));
        check("b2b_out_valid", 128'(ov[sel]), 128'(0));
        wait_out(n, "b2b");
    endtask

    task automatic mid_reset(input int n);
        @(posedge clk); #1;
        send(FIPS_IN, 1'b0, 1'b0);
        if (n == 4) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1;
        check("mr_out_valid", 128'(ov[sel]), 128'(0));
        check("mr_out_state", os[sel], 128'(0));
        check("mr_busy", 128'(bsy[sel]), 128'(0));
        expq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mr_in_ready", 128'(irdy[sel]), 128'(1));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("mr_no_out", 128'(ov[sel]), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] diag;
        int n;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                diag[127-8*(4*((c+r)%4)+r) -: 8] = DIAG_CL[127-32*c-8*r -: 8];
        check("model_fips_fwd", model(FIPS_IN, 1'b0, 1'b0), FIPS_MC);
        check("model_diag", model(diag, 1'b0, 1'b0), DIAG_EX);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            n = 4 >> s;
            do_reset();
            send(FIPS_IN, 1'b0, 1'b0);
            wait_out(n, "fwd");
            check("fips_fwd", os[sel], FIPS_MC);
            @(posedge clk); #1;
            check("out_valid_drop", 128'(ov[sel]), 128'(0));
            send(FIPS_IN, 1'b0, 1'b1);
            wait_out(0, "last");
            check("fips_shiftrows", os[sel], FIPS_SR);
            send(FIPS_SR, 1'b1, 1'b1);
            wait_out(0, "inv_last");
            check("inv_shiftrows", os[sel], INV_EN ? FIPS_IN : model(FIPS_SR, 1'b0, 1'b1));
            send(FIPS_MC, 1'b1, 1'b0);
            wait_out(n, "inv_mix");
            check("inv_mix", os[sel], INV_EN ? FIPS_IN : model(FIPS_MC, 1'b0, 1'b0));
            send(diag, 1'b0, 1'b0);
            wait_out(n, "diag");
            check("diag_cols", os[sel], DIAG_EX);
            backpressure(n);
            mid_reset(n);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
